// File: rtl/median_pkg.sv
// median_pkg: tap count, window pixel indices and a window slicing helper shared by the median blocks
package median_pkg;
  localparam int MED_TAPS = 9;
  localparam int MED_MAX_DW = 16;
  localparam int P_TL = 0;
  localparam int P_TC = 1;
  localparam int P_TR = 2;
  localparam int P_ML = 3;
  localparam int P_C = 4;
  localparam int P_MR = 5;
  localparam int P_BL = 6;
  localparam int P_BC = 7;
  localparam int P_BR = 8;
  // Extract pixel idx of a window packed with dw bits per pixel, p0 at the LSB.
  function automatic logic [MED_MAX_DW-1:0] win_px(input logic [MED_TAPS*MED_MAX_DW-1:0] win, input int idx, input int dw);
    logic [MED_TAPS*MED_MAX_DW-1:0] s;
    s = win >> (idx * dw);
    return s[MED_MAX_DW-1:0] & ((MED_MAX_DW'(1) << dw) - MED_MAX_DW'(1));
  endfunction
endpackage

// File: rtl/median_window_3x3_if.sv
// median_window_3x3_if: pixel stream in, 3x3 window stream out
interface median_window_3x3_if import median_pkg::*; #(parameter int DATA_WIDTH = 8);
  logic in_valid;
  logic in_sof;
  logic [DATA_WIDTH-1:0] in_data;
  logic out_valid;
  logic [MED_TAPS*DATA_WIDTH-1:0] out_win;
  logic out_eol;
  logic out_eof;
  modport master (output in_valid, in_sof, in_data, input out_valid, out_win, out_eol, out_eof);
  modport slave (input in_valid, in_sof, in_data, output out_valid, out_win, out_eol, out_eof);
endinterface

// File: rtl/median_line_buffer.sv
// median_line_buffer: one image line of storage, combinational read-before-write, no reset
module median_line_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH = 640
) (
  input  logic clk,
  input  logic we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  assign dout = mem[addr];
  // Write the new value after the old one has been read out on dout.
  always_ff @(posedge clk)
    if (we) mem[addr] <= din;
endmodule

// File: rtl/median_window_3x3.sv
// median_window_3x3: turns a raster pixel stream into registered 3x3 neighbourhood windows
module median_window_3x3 import median_pkg::*; #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH = 640,
  parameter int IMG_HEIGHT = 480
) (
  input logic clk,
  input logic rst_n,
  median_window_3x3_if.slave bus
);
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  logic [CW-1:0] col_q, col_d, cur_col;
  logic [RW-1:0] row_q, row_d, cur_row;
  logic [DATA_WIDTH-1:0] rd0, rd1;
  logic [MED_TAPS-1:0][DATA_WIDTH-1:0] win_q, win_d;
  logic valid_q, valid_d, eol_q, eol_d, eof_q, eof_d;
  logic acc, last_col, last_row;
  // Position of the incoming pixel (SOF forces 0,0), next counts, window shift and output flags.
  always_comb begin
    acc = bus.in_valid;
    cur_col = (acc && bus.in_sof) ? '0 : col_q;
    cur_row = (acc && bus.in_sof) ? '0 : row_q;
    last_col = cur_col == CW'(IMG_WIDTH - 1);
    last_row = cur_row == RW'(IMG_HEIGHT - 1);
    col_d = !acc ? col_q : last_col ? '0 : cur_col + 1'b1;
    row_d = !acc ? row_q : !last_col ? cur_row : last_row ? '0 : cur_row + 1'b1;
    win_d = acc ? {bus.in_data, win_q[P_BR], win_q[P_BC],
                   rd0, win_q[P_MR], win_q[P_C],
                   rd1, win_q[P_TR], win_q[P_TC]} : win_q;
    valid_d = acc && cur_row >= RW'(2) && cur_col >= CW'(2);
    eol_d = valid_d && last_col;
    eof_d = eol_d && last_row;
  end
  // Counters, window registers and the registered output flags.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
      win_q <= '0;
      valid_q <= 1'b0;
      eol_q <= 1'b0;
      eof_q <= 1'b0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      win_q <= win_d;
      valid_q <= valid_d;
      eol_q <= eol_d;
      eof_q <= eof_d;
    end
  median_line_buffer #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(IMG_WIDTH)) lb0 (
    .clk(clk), .we(acc), .addr(cur_col), .din(bus.in_data), .dout(rd0));
  median_line_buffer #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(IMG_WIDTH)) lb1 (
    .clk(clk), .we(acc), .addr(cur_col), .din(rd0), .dout(rd1));
  assign bus.out_valid = valid_q;
  assign bus.out_win = win_q;
  assign bus.out_eol = eol_q;
  assign bus.out_eof = eof_q;
endmodule

// File: tb/tb_median_window_3x3.sv
// tb_median_window_3x3: random/directed stream checked against a 2D image model of the window rules
module tb_median_window_3x3;
  import median_pkg::*;
  localparam int W = 5;
  localparam int H = 4;
  logic clk = 0;
  logic rst_n = 0;
  int ncmp = 0;
  int nfail = 0;
  logic [73:0] obs [$];
  median_window_3x3_if #(.DATA_WIDTH(8)) bus ();
  median_window_3x3 #(.DATA_WIDTH(8), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [73:0] a, input logic [73:0] e);
    ncmp++;
    if (a !== e) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  // model: image array indexed by (row,col) of the pixel stream
  int mr, mc;
  logic [7:0] img [H][W];
  logic ev, eeol, eeof;
  logic [71:0] ew;
  function automatic int cur_r();
    return bus.in_sof ? 0 : mr;
  endfunction
  function automatic int cur_c();
    return bus.in_sof ? 0 : mc;
  endfunction
  function automatic logic [71:0] mk_win(input int r, input int c, input logic [7:0] d);
    logic [71:0] w;
    for (int i = 0; i < 9; i++)
      w[i*8 +: 8] = (i == 8) ? d : img[r - 2 + i / 3][c - 2 + i % 3];
    return w;
  endfunction
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mr <= 0; mc <= 0; ev <= 0; eeol <= 0; eeof <= 0; ew <= '0;
    end else begin
      ev <= 0; eeol <= 0; eeof <= 0;
      if (bus.in_valid) begin
        img[cur_r()][cur_c()] <= bus.in_data;
        if (cur_r() >= 2 && cur_c() >= 2) begin
          ev <= 1;
          ew <= mk_win(cur_r(), cur_c(), bus.in_data);
          eeol <= cur_c() == W - 1;
          eeof <= cur_c() == W - 1 && cur_r() == H - 1;
        end
        mc <= cur_c() == W - 1 ? 0 : cur_c() + 1;
        mr <= cur_c() != W - 1 ? cur_r() : cur_r() == H - 1 ? 0 : cur_r() + 1;
      end
    end
  // per-cycle compare, 1 time unit after the active edge
  always @(posedge clk) begin
    #1;
    chk("out_valid", 74'(bus.out_valid), 74'(ev));
    chk("out_eol", 74'(bus.out_eol), 74'(eeol));
    chk("out_eof", 74'(bus.out_eof), 74'(eeof));
    if (ev) chk("out_win", 74'(bus.out_win), 74'(ew));
    if (!rst_n) chk("rst_win", 74'(bus.out_win), 74'(0));
    if (rst_n && !bus.in_valid) chk("valid_after_idle", 74'(bus.out_valid), 74'(0));
    if (bus.out_valid) obs.push_back({bus.out_eof, bus.out_eol, bus.out_win});
  end
  function automatic logic [73:0] gold(input int k);
    int f, w, cr, cc;
    logic [71:0] win;
    f = k / 6; w = k % 6; cr = 1 + w / 3; cc = 1 + w % 3;
    for (int i = 0; i < 9; i++)
      win[i*8 +: 8] = 8'(f * 128 + (cr - 1 + i / 3) * 16 + cc - 1 + i % 3);
    return {w == 5, w % 3 == 2, win};
  endfunction
  task automatic check_seq(input string n, input int nf);
    chk({n, "_count"}, 74'(obs.size()), 74'(6 * nf));
    if (obs.size() == 6 * nf)
      for (int k = 0; k < 6 * nf; k++) chk(n, obs[k], gold(k));
  endtask
  task automatic drive_px(input logic [7:0] d, input logic sof, input int idle_pct);
    for (int k = 0; k < 8 && int'($urandom_range(99)) < idle_pct; k++) begin
      @(negedge clk);
      bus.in_valid = 0; bus.in_sof = 0;
    end
    @(negedge clk);
    bus.in_valid = 1; bus.in_sof = sof; bus.in_data = d;
  endtask
  task automatic frame(input logic [7:0] base, input int idle_pct, input int npix, input bit rnd);
    for (int i = 0; i < npix; i++)
      drive_px(rnd ? 8'($urandom) : 8'(base + (i / W) * 16 + i % W), i == 0, idle_pct);
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.in_valid = 0; bus.in_sof = 0;
    end
  endtask
  initial begin
    bus.in_valid = 0; bus.in_sof = 0; bus.in_data = 0;
    repeat (2) @(negedge clk);
    chk("reset_valid", 74'(bus.out_valid), 74'(0));
    chk("reset_flags", 74'({bus.out_eol, bus.out_eof}), 74'(0));
    chk("reset_win", 74'(bus.out_win), 74'(0));
    rst_n = 1;
    // 1: full frame, no gaps
    obs.delete();
    frame(8'h00, 0, W * H, 0);
    idle(3);
    check_seq("t1", 1);
    if (obs.size() > 0) begin
      chk("t1_first_lit", 74'(obs[0][71:0]), 74'(72'h222120121110020100));
      chk("t1_centre", 74'(win_px(144'(obs[0][71:0]), P_C, 8)), 74'(8'h11));
    end
    chk("model_pin_f1", 74'(mk_win(2, 2, 8'h22)), 74'(72'h222120121110020100));
    // 2: same frame with ~40% idle cycles
    obs.delete();
    frame(8'h00, 40, W * H, 0);
    idle(3);
    check_seq("t2", 1);
    // 3: SOF reissued at pixel (1,3)
    obs.delete();
    frame(8'h40, 0, W + 3, 0);
    frame(8'h00, 0, W * H, 0);
    idle(3);
    check_seq("t3", 1);
    // 4: reset pulse at pixel (2,3)
    frame(8'h40, 0, 2 * W + 3, 0);
    @(negedge clk);
    rst_n = 0; bus.in_valid = 1; bus.in_sof = 0; bus.in_data = 8'h63;
    #1;
    chk("t4_rst_valid", 74'(bus.out_valid), 74'(0));
    chk("t4_rst_win", 74'(bus.out_win), 74'(0));
    chk("t4_rst_flags", 74'({bus.out_eol, bus.out_eof}), 74'(0));
    repeat (2) @(negedge clk);
    rst_n = 1; bus.in_valid = 0;
    obs.delete();
    frame(8'h00, 0, W * H, 0);
    idle(3);
    check_seq("t4", 1);
    // 5: two back-to-back frames
    obs.delete();
    frame(8'h00, 0, W * H, 0);
    frame(8'h80, 0, W * H, 0);
    idle(3);
    check_seq("t5", 2);
    if (obs.size() > 6) chk("t5_f2_first_lit", 74'(obs[6][71:0]), 74'(72'hA2A1A0929190828180));
    chk("model_pin_f2", 74'(mk_win(2, 2, 8'hA2)), 74'(72'hA2A1A0929190828180));
    // 7: random pixel data and gaps, checked per cycle by the model
    for (int f = 0; f < 3; f++) begin
      obs.delete();
      frame(8'h00, 30, W * H, 1);
      idle(3);
      chk("t7_count", 74'(obs.size()), 74'(6));
    end
    // 6: only rows 0-1, then idle
    obs.delete();
    frame(8'h00, 0, 2 * W, 0);
    idle(20);
    chk("t6_count", 74'(obs.size()), 74'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
